fp_alu_driver: RTL and testbench

- Initiator side of the float ALU start/ready/valid handshake.
- Buffers operation commands in a small FIFO and issues them to the ALU one at a time.
- Captures each result and flag set, and presents them on a response port with valid/ready flow control.
- Keeps a sticky OR of all returned exception flags for software readback.

---
 rtl/fp_alu_driver.sv | 180 ++++++++++++++++++
 tb/tb_fp_alu_driver.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_driver.sv
// fp_alu_driver: initiator side of the float ALU start/ready/valid handshake.
//   Commands are buffered in a DEPTH-entry FIFO and issued to the ALU one at a
//   time; each result and flag set is held on a valid/ready response port, and
//   a sticky OR of all returned flags is kept for software readback.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_*                   command input (valid/ready), operands, op, mode, rounding
//   alu_op_a/b, alu_op_code, alu_mode_fp, alu_round_mode
//                           operands and controls presented to the ALU
//   alu_start/alu_ready_out issue handshake towards the ALU
//   alu_valid_out/alu_ready_in, alu_result, alu_flags
//                           result handshake from the ALU
//   rsp_*                   captured response (valid/ready), illegal-op marker
//   flags_sticky, clear_sticky
//                           accumulated exception flags and their clear
//   busy                    FSM active or commands still queued
module fp_alu_driver #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_op_a,
    input  logic [N-1:0] cmd_op_b,
    input  logic [2:0]   cmd_op_code,
    input  logic         cmd_mode_fp,
    input  logic         cmd_round_mode,
    output logic [N-1:0] alu_op_a,
    output logic [N-1:0] alu_op_b,
    output logic [2:0]   alu_op_code,
    output logic         alu_mode_fp,
    output logic         alu_round_mode,
    output logic         alu_start,
    input  logic         alu_ready_out,
    input  logic         alu_valid_out,
    output logic         alu_ready_in,
    input  logic [N-1:0] alu_result,
    input  logic [4:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic [4:0]   rsp_flags,
    output logic         rsp_illegal,
    output logic [4:0]   flags_sticky,
    input  logic         clear_sticky,
    output logic         busy
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    // FIFO entry layout: {op_code, mode_fp, round_mode, op_a, op_b}
    localparam int EW = 2 * N + 5;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          full, empty, push, pop, head_legal;
    logic [EW-1:0] head;
    logic [N-1:0]  iss_a_q, iss_a_d, iss_b_q, iss_b_d;
    logic [2:0]    iss_op_q, iss_op_d;
    logic          iss_mode_q, iss_mode_d, iss_rnd_q, iss_rnd_d;
    logic [N-1:0]  rsp_result_q, rsp_result_d;
    logic [4:0]    rsp_flags_q, rsp_flags_d, sticky_q, sticky_d;
    logic          rsp_illegal_q, rsp_illegal_d;

    // The extra top pointer bit separates full (wrapped) from empty.
    assign empty      = wr_q == rd_q;
    assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign pop        = (state_q == IDLE) && !empty;
    assign head       = mem_q[rd_q[AW-1:0]];
    assign head_legal = head[EW-1:EW-3] inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= {cmd_op_code, cmd_mode_fp, cmd_round_mode, cmd_op_a, cmd_op_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push)
                wr_q <= wr_q + (AW + 1)'(1);
            if (pop)
                rd_q <= rd_q + (AW + 1)'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        iss_a_d       = iss_a_q;
        iss_b_d       = iss_b_q;
        iss_op_d      = iss_op_q;
        iss_mode_d    = iss_mode_q;
        iss_rnd_d     = iss_rnd_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_illegal_d = rsp_illegal_q;
        sticky_d      = sticky_q;
        case (state_q)
            IDLE: if (!empty) begin
                {iss_op_d, iss_mode_d, iss_rnd_d, iss_a_d, iss_b_d} = head;
                if (head_legal) begin
                    state_d = ISSUE;
                end else begin
                    // Unsupported op never reaches the ALU; answer directly.
                    rsp_result_d  = '0;
                    rsp_flags_d   = '0;
                    rsp_illegal_d = 1'b1;
                    state_d       = RESP;
                end
            end
            ISSUE: if (alu_ready_out) state_d = WAIT;
            WAIT: if (alu_valid_out) begin
                rsp_result_d  = alu_result;
                rsp_flags_d   = alu_flags;
                rsp_illegal_d = 1'b0;
                state_d       = RESP;
            end
            RESP: if (rsp_ready) begin
                sticky_d = sticky_q | rsp_flags_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_sticky)
            sticky_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            iss_a_q       <= '0;
            iss_b_q       <= '0;
            iss_op_q      <= '0;
            iss_mode_q    <= 1'b0;
            iss_rnd_q     <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_illegal_q <= 1'b0;
            sticky_q      <= '0;
        end else begin
            state_q       <= state_d;
            iss_a_q       <= iss_a_d;
            iss_b_q       <= iss_b_d;
            iss_op_q      <= iss_op_d;
            iss_mode_q    <= iss_mode_d;
            iss_rnd_q     <= iss_rnd_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_illegal_q <= rsp_illegal_d;
            sticky_q      <= sticky_d;
        end
    end

    // Issue registers only change in IDLE, so the ALU inputs stay stable
    // from ISSUE entry until the result is taken in WAIT.
    assign alu_op_a       = iss_a_q;
    assign alu_op_b       = iss_b_q;
    assign alu_op_code    = iss_op_q;
    assign alu_mode_fp    = iss_mode_q;
    assign alu_round_mode = iss_rnd_q;
    assign alu_start      = state_q == ISSUE;
    assign alu_ready_in   = state_q == WAIT;
    assign rsp_valid      = state_q == RESP;
    assign rsp_result     = rsp_result_q;
    assign rsp_flags      = rsp_flags_q;
    assign rsp_illegal    = rsp_illegal_q;
    assign flags_sticky   = sticky_q;
    assign busy           = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_fp_alu_driver.sv
// tb_fp_alu_driver: directed bench for fp_alu_driver with a stub ALU and a
//   transaction-level model (expected-response queue, sticky-flag model).
module tb_fp_alu_driver;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3, BAD = 3'b111;

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        mode, rnd;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_mode_fp, cmd_round_mode;
    logic [31:0] cmd_op_a, cmd_op_b;
    logic [2:0]  cmd_op_code;
    logic [31:0] alu_op_a, alu_op_b, alu_result, rsp_result;
    logic [2:0]  alu_op_code;
    logic        alu_mode_fp, alu_round_mode, alu_start, alu_ready_out;
    logic        alu_valid_out, alu_ready_in, rsp_valid, rsp_ready, rsp_illegal;
    logic [4:0]  alu_flags, rsp_flags, flags_sticky;
    logic        clear_sticky, busy;

    int nvec = 0, nerr = 0, n_start = 0, alu_lat = 1;
    cmd_t        exp_q[$], iss_q[$];
    logic [4:0]  sticky_m = '0;
    logic        hold_v = 1'b0;
    logic [37:0] hold_rsp;
    logic [67:0] held;
    logic [31:0] last_res;
    logic [4:0]  last_flags;
    logic        last_ill;

    always #5 clk = ~clk;

    fp_alu_driver dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_op_code(cmd_op_code),
        .cmd_mode_fp(cmd_mode_fp), .cmd_round_mode(cmd_round_mode),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
        .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
        .alu_start(alu_start), .alu_ready_out(alu_ready_out),
        .alu_valid_out(alu_valid_out), .alu_ready_in(alu_ready_in),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal),
        .flags_sticky(flags_sticky), .clear_sticky(clear_sticky), .busy(busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: event did not occur", nm);
    endtask

    // Stub ALU behaviour: a few IEEE vectors worked out by hand, integer
    // arithmetic for everything else (the driver only transports values).
    function automatic logic [36:0] alu_fn(input logic [31:0] a, b, input logic [2:0] op);
        if (op == ADD && a == 32'h3FC00000 && b == 32'h40100000) return {5'b00000, 32'h40700000};
        if (op == MUL && a == 32'h40000000 && b == 32'h40400000) return {5'b00000, 32'h40C00000};
        if (op == DIV && a == 32'h3F800000 && b == 32'h00000000) return {5'b00001, 32'h7F800000};
        if (op == MUL && a == 32'h7F7FFFFF && b == 32'h40000000) return {5'b10000, 32'h7F800000};
        case (op)
            ADD:     return {5'b0, a + b};
            SUB:     return {5'b0, a - b};
            MUL:     return {5'b0, a * b};
            default: return {5'b0, a ^ b};
        endcase
    endfunction

    function automatic logic [37:0] exp_rsp(input cmd_t c);
        return (c.op <= DIV) ? {1'b0, alu_fn(c.a, c.b, c.op)} : {1'b1, 37'b0};
    endfunction

    // Stub ALU: always ready when alu_ready_out allows, result after alu_lat cycles.
    initial begin
        logic [36:0] fr;
        alu_valid_out = 1'b0;
        alu_result = '0;
        alu_flags = '0;
        forever begin
            @(negedge clk);
            if (rst_n && alu_start && alu_ready_out) begin
                fr = alu_fn(alu_op_a, alu_op_b, alu_op_code);
                n_start++;
                repeat (alu_lat) @(posedge clk);
                #1;
                alu_valid_out = 1'b1;
                {alu_flags, alu_result} = fr;
                @(posedge clk);
                #1;
                alu_valid_out = 1'b0;
                alu_result = 32'hDEADBEEF;
                alu_flags = 5'h1F;
            end
        end
    end

    // Compare process: model of outstanding commands, issue order and sticky flags.
    always @(negedge clk) begin
        cmd_t c;
        logic [37:0] e;
        logic [4:0] hs;
        if (!rst_n) begin
            exp_q.delete();
            iss_q.delete();
            sticky_m = '0;
            hold_v = 1'b0;
        end else begin
            hs = '0;
            chk("busy", busy, exp_q.size() != 0);
            chk("sticky", flags_sticky, sticky_m);
            if (hold_v) begin
                chk("rsp_hold_valid", rsp_valid, 1'b1);
                chk("rsp_hold_data", {rsp_illegal, rsp_flags, rsp_result}, hold_rsp);
            end
            if (rsp_valid)
                chk("resp_quiet_alu", {alu_start, alu_ready_in}, 2'b00);
            if (alu_ready_in)
                chk("wait_stable", {alu_op_code, alu_mode_fp, alu_op_a, alu_op_b}, held);
            if (alu_start && alu_ready_out) begin
                if (iss_q.size() == 0) begin
                    miss("expected_issue");
                end else begin
                    c = iss_q.pop_front();
                    chk("issue", {alu_op_code, alu_mode_fp, alu_round_mode, alu_op_a, alu_op_b},
                        {c.op, c.mode, c.rnd, c.a, c.b});
                end
                held = {alu_op_code, alu_mode_fp, alu_op_a, alu_op_b};
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    miss("expected_response");
                end else begin
                    c = exp_q.pop_front();
                    e = exp_rsp(c);
                    hs = e[36:32];
                    chk("rsp", {rsp_illegal, rsp_flags, rsp_result}, e);
                end
                last_res = rsp_result;
                last_flags = rsp_flags;
                last_ill = rsp_illegal;
            end
            sticky_m = clear_sticky ? 5'b0 : (sticky_m | hs);
            hold_v = rsp_valid && !rsp_ready;
            hold_rsp = {rsp_illegal, rsp_flags, rsp_result};
            if (cmd_valid && cmd_ready) begin
                c = '{a: cmd_op_a, b: cmd_op_b, op: cmd_op_code, mode: cmd_mode_fp, rnd: cmd_round_mode};
                exp_q.push_back(c);
                if (c.op <= DIV)
                    iss_q.push_back(c);
            end
        end
    end

    task automatic push(input logic [31:0] a, b, input logic [2:0] op, input logic mode, rnd);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_op_a = a;
        cmd_op_b = b;
        cmd_op_code = op;
        cmd_mode_fp = mode;
        cmd_round_mode = rnd;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready)
            miss("push_accept");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        @(negedge clk);
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_idle"}, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string nm, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 100);
        if (!rsp_valid)
            miss(nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, s0, acc;
        logic r;
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        cmd_op_a = '0;
        cmd_op_b = '0;
        cmd_op_code = '0;
        cmd_mode_fp = 1'b0;
        cmd_round_mode = 1'b0;
        alu_ready_out = 1'b1;
        rsp_ready = 1'b1;
        clear_sticky = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {cmd_ready, rsp_valid, alu_start, alu_ready_in, busy, flags_sticky, rsp_illegal},
            {1'b1, 10'b0});
        chk("reset_data", {alu_op_a, alu_op_b, alu_op_code, rsp_result, rsp_flags}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD single, minimum latency with a one-cycle ALU
        s0 = n_start;
        push(32'h3FC00000, 32'h40100000, ADD, 1'b1, 1'b0);
        wait_rsp("add_rsp", cyc);
        chk("add_latency", cyc, 4);
        chk("add_result", {rsp_illegal, rsp_flags, rsp_result}, {1'b0, 5'b0, 32'h40700000});
        wait_idle("add");
        chk("add_starts", n_start - s0, 1);

        // MUL single; op stability in WAIT is checked by the compare process
        alu_lat = 3;
        push(32'h40000000, 32'h40400000, MUL, 1'b1, 1'b1);
        wait_idle("mul");
        chk("mul_result", last_res, 32'h40C00000);
        alu_lat = 1;

        // Half precision: upper bits of the ALU result pass through untouched
        push(32'hABCD3C00, 32'h00000400, SUB, 1'b0, 1'b1);
        wait_idle("half");
        chk("half_result", last_res, 32'hABCD3800);

        // Backpressure: ALU never ready, commands offered every cycle
        alu_ready_out = 1'b0;
        s0 = n_start;
        acc = 0;
        cmd_valid = 1'b1;
        cmd_op_code = ADD;
        cmd_mode_fp = 1'b1;
        cmd_round_mode = 1'b0;
        cmd_op_a = 32'h100;
        cmd_op_b = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc++;
                cmd_op_a = cmd_op_a + 32'd1;
                cmd_op_b = cmd_op_b + 32'h10;
            end
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        chk("bp_full", cmd_ready, 1'b0);
        chk("bp_start_held", alu_start, 1'b1);
        chk("bp_no_transfer", n_start - s0, 0);
        alu_ready_out = 1'b1;
        wait_idle("bp");
        chk("bp_starts", n_start - s0, 5);
        chk("bp_last", last_res, 32'h104 + 32'h40);

        // Response stall with a second command queued behind it
        rsp_ready = 1'b0;
        s0 = n_start;
        push(32'd1000, 32'd1, SUB, 1'b1, 1'b0);
        push(32'd5, 32'd6, MUL, 1'b1, 1'b0);
        wait_rsp("stall_rsp", cyc);
        repeat (10) @(negedge clk);
        chk("stall_result", {rsp_valid, rsp_result}, {1'b1, 32'd999});
        chk("stall_starts", n_start - s0, 1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle("stall");
        chk("stall_last", last_res, 32'd30);
        chk("stall_starts_after", n_start - s0, 2);

        // Illegal op never reaches the ALU
        s0 = n_start;
        push(32'h12345678, 32'h9ABCDEF0, BAD, 1'b1, 1'b1);
        wait_idle("illegal");
        chk("ill_starts", n_start - s0, 0);
        chk("ill_rsp", {last_ill, last_res, last_flags}, {1'b1, 32'h0, 5'h0});
        chk("ill_state", {busy, rsp_valid}, 2'b00);

        // Sticky flags accumulate, then a clear wins over a coincident response
        clear_sticky = 1'b1;
        @(posedge clk);
        #1 clear_sticky = 1'b0;
        push(32'h3F800000, 32'h00000000, DIV, 1'b1, 1'b0);
        push(32'h7F7FFFFF, 32'h40000000, MUL, 1'b1, 1'b0);
        wait_idle("sticky");
        chk("sticky_or", flags_sticky, 5'b10001);
        rsp_ready = 1'b0;
        push(32'h3F800000, 32'h00000000, DIV, 1'b1, 1'b0);
        wait_rsp("sticky_rsp", cyc);
        chk("sticky_rsp_flags", rsp_flags, 5'b00001);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        clear_sticky = 1'b1;
        @(posedge clk);
        #1 clear_sticky = 1'b0;
        chk("sticky_clear", {rsp_valid, flags_sticky}, 6'b0);

        // Reset asserted while waiting on the ALU
        alu_lat = 6;
        push(32'd7, 32'd8, ADD, 1'b1, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!alu_ready_in && cyc < 50);
        chk("rst_in_wait", alu_ready_in, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {rsp_valid, alu_ready_in, alu_start, busy, cmd_ready}, 5'b00001);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_late_result_ignored", {rsp_valid, busy}, 2'b00);
        alu_lat = 1;
        push(32'd7, 32'd8, ADD, 1'b1, 1'b0);
        wait_idle("recover");
        chk("recover_result", last_res, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
